// File: rtl/fifo1_rr_arbiter.sv
// Round-robin arbiter sharing one Fifo1 enqueue port among NREQ producers.
// Grant is registered, so every requester RDY is independent of every ENA.
module fifo1_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 128,
  parameter int BURST = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         in_want,
  input  logic [NREQ-1:0]         in_enq__ENA,
  input  logic [NREQ*WIDTH-1:0]   in_enq_v,
  output logic [NREQ-1:0]         in_enq__RDY,
  output logic                    out_enq__ENA,
  output logic [WIDTH-1:0]        out_enq_v,
  input  logic                    out_enq__RDY,
  output logic [$clog2(NREQ)-1:0] out_src,
  output logic                    out_busy
);

  localparam int SW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_cur;
  logic [SW-1:0]   w_cur_nxt;
  logic [SW-1:0]   w_pick;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            w_gv;
  logic            w_xfer;
  logic            w_rearb;
  logic [WIDTH-1:0] w_slot [NREQ];

  assign w_gv = (r_state == GRANT);

  for (genvar g = 0; g < NREQ; g++) begin : g_slot
    assign w_slot[g] = in_enq_v[g*WIDTH +: WIDTH];
  end

  always_comb begin
    w_pick = r_cur;
    for (int k = NREQ; k >= 1; k--) begin
      if (in_want[r_cur + SW'(k)]) begin
        w_pick = r_cur + SW'(k);
      end
    end
  end

  always_comb begin
    in_enq__RDY = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_enq__RDY[i] = w_gv & nRST & out_enq__RDY
                     & (r_cur == SW'(i));
    end
  end

  assign w_xfer       = |(in_enq__ENA & in_enq__RDY);
  assign out_enq__ENA = w_xfer;
  assign out_enq_v    = w_slot[r_cur];
  assign out_src      = r_cur;
  assign out_busy     = w_gv & nRST;

  assign w_rearb = !in_want[r_cur]
                 | (w_xfer & (r_cnt == 4'(BURST - 1)));

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cur   <= SW'(NREQ - 1);
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (|in_want) begin
          w_state_nxt = GRANT;
          w_cur_nxt   = w_pick;
          w_cnt_nxt   = 4'd0;
        end
      end
      GRANT: begin
        if (w_rearb) begin
          w_cnt_nxt = 4'd0;
          if (|in_want) begin
            w_cur_nxt = w_pick;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
